// File: rtl/lenet_pkg.sv
// lenet_pkg: shared image geometry and pixel/window types for the LeNet front end
package lenet_pkg;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K = 5;
    localparam int DW = 8;
    typedef logic signed [DW-1:0] pixel_t;
    typedef pixel_t win_t [K][K];
endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// line_buffer: one image row of pixels, read-before-write at a shared column index
module line_buffer
    import lenet_pkg::*;
(
    input logic clk,
    input logic we,
    input logic [$clog2(IMG_W)-1:0] addr,
    input pixel_t din,
    output pixel_t dout
);
    pixel_t mem [IMG_W];
    assign dout = mem[addr];
    // old pixel at this column is read combinationally, then replaced on the edge
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: KxK sliding-window generator over a raster image; optional s_last framing check under WINGEN_FRAME_CHK_EN
module conv_window_gen
    import lenet_pkg::*;
(
    input logic clk,
    input logic rst,
    input logic s_valid,
    output logic s_ready,
    input logic [DW-1:0] s_data,
    input logic s_last,
    output logic m_valid,
    input logic m_ready,
    output logic [K*K*DW-1:0] m_win,
    output logic m_last,
    output logic frame_err
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_MAX = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_WIN = CW'(K - 1);
    localparam logic [RW-1:0] R_MAX = RW'(IMG_H - 1);
    localparam logic [RW-1:0] R_WIN = RW'(K - 1);
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic acc, emit, at_end, resync;
    pixel_t lb_out [K-1];
    pixel_t right [K];
    win_t win, win_nxt;
    logic [K*K*DW-1:0] win_flat;
    assign s_ready = !m_valid || m_ready;
    assign acc = s_valid && s_ready;
    assign emit = row >= R_WIN && col >= C_WIN;
    assign at_end = row == R_MAX && col == C_MAX;
    genvar g;
    for (g = 0; g < K-1; g++) begin : g_lb
        if (g == 0) begin : g_head
            line_buffer u_lb (.clk(clk), .we(acc), .addr(col), .din(pixel_t'(s_data)), .dout(lb_out[g]));
        end else begin : g_tail
            line_buffer u_lb (.clk(clk), .we(acc), .addr(col), .din(lb_out[g-1]), .dout(lb_out[g]));
        end
    end
    // next window: shift left one column, new right column has the oldest row on top and s_data at the bottom
    always_comb begin
        right[K-1] = pixel_t'(s_data);
        for (int i = 0; i < K-1; i++) right[i] = lb_out[K-2-i];
        win_flat = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K-1; j++) win_nxt[i][j] = win[i][j+1];
            win_nxt[i][K-1] = right[i];
            for (int j = 0; j < K; j++) win_flat[(i*K+j)*DW +: DW] = win_nxt[i][j];
        end
    end
`ifdef WINGEN_FRAME_CHK_EN
    assign resync = s_last;
    // sticky error whenever s_last disagrees with the counter position
    always_ff @(posedge clk) begin
        if (rst) frame_err <= 1'b0;
        else if (acc && (s_last != at_end)) frame_err <= 1'b1;
    end
`else
    logic unused_last;
    assign unused_last = s_last;
    assign resync = 1'b0;
    assign frame_err = 1'b0;
`endif
    // raster position of the next pixel to be accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (acc) begin
            if (resync || at_end) begin
                row <= '0;
                col <= '0;
            end else if (col == C_MAX) begin
                row <= row + 1'b1;
                col <= '0;
            end else begin
                col <= col + 1'b1;
            end
        end
    end
    // window register is never cleared; column gating guarantees K fresh columns before use
    always_ff @(posedge clk) begin
        if (acc) win <= win_nxt;
    end
    // output register: load a complete window, hold under backpressure, drop when taken
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_win <= '0;
            m_last <= 1'b0;
        end else if (acc && emit) begin
            m_valid <= 1'b1;
            m_win <= win_flat;
            m_last <= at_end;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last <= 1'b0;
        end
    end
endmodule
